// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Two-entry pipeline register with a skid buffer. Payload and control travel
// together from the upstream handshake (in_*) to the downstream handshake
// (out_*). in_ready comes straight from a flop, so the stage breaks the
// combinational ready path between the two sides. The skid entry catches the
// one entry that upstream may push in the cycle in which downstream stalls.
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, occupancy 0
//   ST_ONE   | main valid, skid empty, occupancy 1
//   ST_FULL  | main and skid valid, occupancy 2, in_ready low
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous kill of every held entry (wins over all events)
//   in_valid   upstream holds a valid entry
//   in_ready   stage can accept an entry this cycle (state only)
//   in_data    upstream payload, DATA_W bits
//   in_ctrl    upstream control bundle, CTRL_W bits
//   out_valid  stage presents a valid entry
//   out_ready  downstream accepts the presented entry
//   out_data   presented payload (always the main entry)
//   out_ctrl   presented control bundle, forced to zero when out_valid=0
//   occupancy  number of held entries, 0..2
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              in_xfer;
    logic              out_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;

    // -----------------------------------------------------------------------
    // Handshake decode. Both ready and valid are pure functions of the state
    // flops, so neither side sees a combinational path through this stage.
    // -----------------------------------------------------------------------
    assign in_ready  = (state == ST_EMPTY) || (state == ST_ONE);
    assign out_valid = (state == ST_ONE)   || (state == ST_FULL);

    assign in_xfer   = in_valid  && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // -----------------------------------------------------------------------
    // Next-state and load-enable decode.
    // Flush sends the stage to EMPTY and suppresses every load: an input
    // transfer in the flush cycle is consumed by the handshake and dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;

        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        // Main drains and refills in the same cycle.
                        load_main_in = 1'b1;
                        state_nxt    = ST_ONE;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the newcomer in skid.
                        load_skid_in = 1'b1;
                        state_nxt    = ST_FULL;
                    end else if (out_xfer) begin
                        state_nxt    = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    if (out_xfer) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end

                default: begin
                    // Unreachable encoding; recover to a clean empty stage.
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Main entry. Flush does not touch payload; the invalid entry is hidden
    // by out_valid and by the control gating below.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
        end else if (load_main_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end
    end

    // -----------------------------------------------------------------------
    // Skid entry
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (load_skid_in) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter: counts back-pressure cycles, sticks at all-ones, and is
    // cleared only by reset so it survives flushes.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Output views
    // -----------------------------------------------------------------------
    assign out_data = main_data;

    // Control fields (regwrite, memwrite, ...) must never look live on an
    // invalid slot, so they are zeroed rather than left holding stale values.
    assign out_ctrl = out_valid ? main_ctrl : '0;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 16;
    localparam int CNT_WS = 2;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [DATA_W-1:0] s_out_data;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [1:0]        s_occupancy;
    logic [CNT_WS-1:0] s_stall_cnt;

    int total;
    int bad;

    pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    // Narrow stall counter copy, fed the same stimulus, to see saturation.
    pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_WS)) dut_small (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = {{(DATA_W-8){1'b0}}, d};
        in_ctrl  = {4'hC, d};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags: out_valid=%0b occ=%0d in_ready=%0b want 0 0 1", out_valid, occupancy, in_ready);
        end
        total++;
        if (out_data !== '0 || out_ctrl !== '0 || stall_cnt !== '0) begin
            bad++;
            $display("FAIL reset_values: data=%0h ctrl=%0h stall=%0d want 0 0 0", out_data, out_ctrl, stall_cnt);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 8'h11);
        tick();
        drive(1'b0, 8'h00);
        total++;
        if (out_valid !== 1'b1 || out_data !== 128'h11 || out_ctrl !== 12'hC11 || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL single_latency: v=%0b data=%0h ctrl=%0h occ=%0d want 1 11 c11 1", out_valid, out_data, out_ctrl, occupancy);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL single_drain: v=%0b ctrl=%0h occ=%0d want 0 0 0", out_valid, out_ctrl, occupancy);
        end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        drive(1'b1, 8'h01);
        tick();
        drive(1'b1, 8'h02);
        tick();
        drive(1'b1, 8'h03);
        tick();
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 128'h1) begin
            bad++;
            $display("FAIL fill_full: occ=%0d in_ready=%0b data=%0h want 2 0 1", occupancy, in_ready, out_data);
        end
        // 0x3 stays on the input until space opens up.
        out_ready = 1'b1;
        tick();
        total++;
        if (out_data !== 128'h2 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_second: data=%0h occ=%0d v=%0b want 2 1 1", out_data, occupancy, out_valid);
        end
        tick();
        drive(1'b0, 8'h00);
        total++;
        if (out_data !== 128'h3 || out_ctrl !== 12'hC03 || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL drain_third: data=%0h ctrl=%0h occ=%0d want 3 c03 1", out_data, out_ctrl, occupancy);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL drain_empty: v=%0b occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 8'h0A);
        tick();
        drive(1'b1, 8'h0B);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h0C);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 12'h000 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_full: occ=%0d v=%0b ctrl=%0h in_ready=%0b want 0 0 0 1", occupancy, out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_ghost: v=%0b want 0", out_valid);
        end
        // Flush in ONE with an input transfer in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 8'h0E);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h0F);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_one: occ=%0d v=%0b want 0 0", occupancy, out_valid);
        end
        drive(1'b1, 8'h10);
        tick();
        drive(1'b0, 8'h00);
        total++;
        if (out_data !== 128'h10 || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL flush_next_entry: data=%0h occ=%0d want 10 1", out_data, occupancy);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'h44);
        tick();
        drive(1'b0, 8'h00);
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL stall_start: cnt=%0d want 0", stall_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (stall_cnt !== 16'd5) begin
            bad++;
            $display("FAIL stall_five: cnt=%0d want 5", stall_cnt);
        end
        tick();
        total++;
        if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd6) begin
            bad++;
            $display("FAIL stall_saturate: small=%0d big=%0d want 3 6", s_stall_cnt, stall_cnt);
        end
        total++;
        if (s_out_valid !== 1'b1 || s_in_ready !== 1'b1 || s_occupancy !== 2'd1 ||
            s_out_data !== 128'h44 || s_out_ctrl !== 12'hC44) begin
            bad++;
            $display("FAIL small_copy: v=%0b rdy=%0b occ=%0d data=%0h ctrl=%0h want 1 1 1 44 c44",
                     s_out_valid, s_in_ready, s_occupancy, s_out_data, s_out_ctrl);
        end
        // Accepting the entry stops the counter.
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (stall_cnt !== 16'd6) begin
            bad++;
            $display("FAIL stall_hold: cnt=%0d want 6", stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'h55);
        tick();
        drive(1'b1, 8'h66);
        tick();
        drive(1'b0, 8'h00);
        tick();
        total++;
        if (occupancy !== 2'd2 || stall_cnt === 16'd0) begin
            bad++;
            $display("FAIL areset_setup: occ=%0d cnt=%0d want 2 nonzero", occupancy, stall_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || stall_cnt !== 16'd0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL areset_async: v=%0b ctrl=%0h cnt=%0d occ=%0d want 0 0 0 0", out_valid, out_ctrl, stall_cnt, occupancy);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        out_ready = 1'b1;
        drive(1'b1, 8'h77);
        tick();
        drive(1'b0, 8'h00);
        total++;
        if (out_data !== 128'h77 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_first_xfer: data=%0h occ=%0d v=%0b want 77 1 1", out_data, occupancy, out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'h20 + 8'(i);
            drive(1'b1, d);
            tick();
            total++;
            if (out_data !== {{(DATA_W-8){1'b0}}, d} || occupancy !== 2'd1 ||
                in_ready !== 1'b1 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d: data=%0h occ=%0d rdy=%0b v=%0b want %0h 1 1 1",
                         i, out_data, occupancy, in_ready, out_valid, d);
            end
        end
        drive(1'b0, 8'h00);
        tick();
        total++;
        if (occupancy !== 2'd0) begin
            bad++;
            $display("FAIL b2b_end: occ=%0d want 0", occupancy);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_flush();
        test_stall();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
